iobus_response_mux: RTL

//  Return path of the MicroBlaze MCS IO bus, directly downstream of the address compare stage.
//  - Consumes the one-hot target strobes; the top bit is the default (unmapped) responder.
//  - Tracks the single outstanding transaction and muxes the selected core's ready/read data back to the CPU.
//  - Answers unmapped accesses itself.
//  - Ends hung transactions with a watchdog timeout and records a sticky error with the faulting address.

---
 rtl/iobus_response_mux_pkg.sv | 8 +
 rtl/iobus_response_mux_if.sv | 22 ++
 rtl/iobus_response_mux_timeout.sv | 19 +
 rtl/iobus_response_mux.sv | 84 ++++++++
 4 files changed

// File: rtl/iobus_response_mux_pkg.sv
// iobus_pkg: shared IO bus constants, state encoding and default response data.
package iobus_pkg;
   localparam int IOBUS_ADDR_W = 32;
   localparam int IOBUS_DATA_W = 32;
   localparam logic [IOBUS_DATA_W-1:0] IOBUS_DEFAULT_DATA = 32'h0000_0000;
   localparam logic [IOBUS_DATA_W-1:0] IOBUS_ERROR_DATA = 32'hDEAD_BEEF;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DFLT = 2'd2, S_TOUT = 2'd3} iobus_state_e;
endpackage

// File: rtl/iobus_response_mux_if.sv
// iobus_response_mux_if: strobes, core returns and responses between MCS side and the response mux.
interface iobus_response_mux_if import iobus_pkg::*; #(parameter int CORE_COUNT = 2);
   logic [CORE_COUNT:0] strobe_in;
   logic io_read_strobe;
   logic [IOBUS_ADDR_W-1:0] io_address;
   logic [CORE_COUNT-1:0] core_ready;
   logic [IOBUS_DATA_W*CORE_COUNT-1:0] core_read_data;
   logic err_clear;
   logic io_ready;
   logic [IOBUS_DATA_W-1:0] io_read_data;
   logic bus_error;
   logic overlap_error;
   logic [IOBUS_ADDR_W-1:0] err_address;
   modport master (
      output strobe_in, io_read_strobe, io_address, core_ready, core_read_data, err_clear,
      input io_ready, io_read_data, bus_error, overlap_error, err_address
   );
   modport slave (
      input strobe_in, io_read_strobe, io_address, core_ready, core_read_data, err_clear,
      output io_ready, io_read_data, bus_error, overlap_error, err_address
   );
endinterface

// File: rtl/iobus_response_mux_timeout.sv
// iobus_timeout_counter: WAIT-state watchdog, expired while the count sits at TIMEOUT_CYCLES-1.
module iobus_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYCLES);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign expired = cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/iobus_response_mux.sv
// iobus_response_mux: tracks the one outstanding IO bus access and returns core, default or timeout responses.
module iobus_response_mux import iobus_pkg::*; #(
   parameter int CORE_COUNT = 2,
   parameter int TIMEOUT_CYCLES = 256,
   parameter logic [IOBUS_DATA_W-1:0] DEFAULT_DATA = IOBUS_DEFAULT_DATA,
   parameter logic [IOBUS_DATA_W-1:0] ERROR_DATA = IOBUS_ERROR_DATA
) (
   input logic clk,
   input logic rst,
   iobus_response_mux_if.slave bus
);
   localparam int SEL_W = CORE_COUNT > 1 ? $clog2(CORE_COUNT) : 1;
   iobus_state_e state_q;
   logic [SEL_W-1:0] sel_q;
   logic rd_q, ready_q, bus_error_q, overlap_q, expired, any_strobe, sel_ready;
   logic [IOBUS_ADDR_W-1:0] addr_q, err_addr_q;
   logic [IOBUS_DATA_W-1:0] data_q, sel_data;
   int low;
   // Lowest set strobe bit wins; CORE_COUNT means the default responder.
   always_comb begin
      low = CORE_COUNT;
      for (int i = CORE_COUNT; i >= 0; i--) if (bus.strobe_in[i]) low = i;
   end
   assign any_strobe = |bus.strobe_in;
   assign sel_ready = bus.core_ready[sel_q];
   assign sel_data = bus.core_read_data[IOBUS_DATA_W*int'(sel_q) +: IOBUS_DATA_W];
   iobus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk(clk), .rst(rst), .clear(state_q != S_WAIT), .enable(state_q == S_WAIT), .expired(expired)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q <= '0;
         rd_q <= 1'b0;
         addr_q <= '0;
         ready_q <= 1'b0;
         data_q <= '0;
         bus_error_q <= 1'b0;
         overlap_q <= 1'b0;
         err_addr_q <= '0;
      end else begin
         ready_q <= 1'b0;
         data_q <= '0;
         if (bus.err_clear) begin
            bus_error_q <= 1'b0;
            overlap_q <= 1'b0;
            err_addr_q <= '0;
         end
         if (state_q != S_IDLE && any_strobe) overlap_q <= 1'b1;
         case (state_q)
            S_IDLE: if (any_strobe) begin
               rd_q <= bus.io_read_strobe;
               if (low == CORE_COUNT) begin
                  state_q <= S_DFLT;
                  ready_q <= 1'b1;
                  data_q <= bus.io_read_strobe ? DEFAULT_DATA : '0;
               end else begin
                  state_q <= S_WAIT;
                  sel_q <= SEL_W'(low);
                  addr_q <= bus.io_address;
               end
            end
            // Ready beats expiry when both land in the same cycle.
            S_WAIT: if (sel_ready) begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               data_q <= rd_q ? sel_data : '0;
            end else if (expired) begin
               state_q <= S_TOUT;
               ready_q <= 1'b1;
               data_q <= rd_q ? ERROR_DATA : '0;
               bus_error_q <= 1'b1;
               if (!bus_error_q || bus.err_clear) err_addr_q <= addr_q;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign bus.io_ready = ready_q;
   assign bus.io_read_data = data_q;
   assign bus.bus_error = bus_error_q;
   assign bus.overlap_error = overlap_q;
   assign bus.err_address = err_addr_q;
endmodule
